// File: rtl/core_lsu.sv
// Load/store unit: accepts one memory request from core_ex, runs a req/ack
// bus cycle, aligns/extends load data into a single-cycle writeback, and
// reports misaligned requests and bus timeouts as single-cycle pulses.
module core_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_in,
  input  logic        ex_is_load_in,
  input  logic        ex_is_store_in,
  input  logic [2:0]  ex_func3_in,
  input  logic [31:0] ex_addr_in,
  input  logic [31:0] ex_store_data_in,
  input  logic [4:0]  ex_rd_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wstrb_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_rdata_in,
  output logic        reg_we_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] reg_write_data_out,
  output logic        hold_flag_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  // Counter value at which a BUS cycle without ack is aborted.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_cnt_q;
  logic        is_load_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [1:0]  offs_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        reg_we_q;
  logic [4:0]  reg_addr_q;
  logic [31:0] reg_data_q;
  logic        misalign_q;
  logic        bus_err_q;

  logic        legal;
  logic        misaligned;
  logic        idle_req;
  logic        accept;
  logic        in_bus;
  logic        tmo_hit;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  assign in_bus = (state_q == StBus);

  // Request decode: funct3 legality, alignment and accept condition.
  always_comb begin
    legal = 1'b0;
    if (ex_is_load_in) begin
      unique case (ex_func3_in)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (ex_is_store_in) begin
      unique case (ex_func3_in)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
    misaligned = ((ex_func3_in[1:0] == 2'b01) && ex_addr_in[0]) ||
                 ((ex_func3_in[1:0] == 2'b10) && (ex_addr_in[1:0] != 2'b00));
    idle_req   = (state_q == StIdle) && ex_valid_in && (ex_is_load_in || ex_is_store_in) && legal;
    accept     = idle_req && !misaligned;
  end

  // Store lane replication and byte strobes; loads write nothing.
  always_comb begin
    wdata_d = ex_store_data_in;
    wstrb_d = 4'b0000;
    if (ex_is_store_in) begin
      unique case (ex_func3_in[1:0])
        2'b00: begin
          wdata_d = {4{ex_store_data_in[7:0]}};
          wstrb_d = 4'b0001 << ex_addr_in[1:0];
        end
        2'b01: begin
          wdata_d = {2{ex_store_data_in[15:0]}};
          wstrb_d = 4'b0011 << ex_addr_in[1:0];
        end
        default: begin
          wdata_d = ex_store_data_in;
          wstrb_d = 4'b1111;
        end
      endcase
    end
  end

  // Next-state logic; an ack in the terminal-count cycle takes priority.
  always_comb begin
    state_d = state_q;
    tmo_hit = in_bus && !mem_ack_in && (tmo_cnt_q == TmoLast);
    unique case (state_q)
      StIdle: if (accept) state_d = StBus;
      StBus:  if (mem_ack_in || tmo_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Request latch and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      is_load_q <= 1'b0;
      we_q      <= 1'b0;
      func3_q   <= '0;
      offs_q    <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
      is_load_q <= ex_is_load_in;
      we_q      <= ex_is_store_in;
      func3_q   <= ex_func3_in;
      offs_q    <= ex_addr_in[1:0];
      rd_q      <= ex_rd_in;
      addr_q    <= {ex_addr_in[31:2], 2'b00};
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end else if (in_bus && !mem_ack_in) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    rdata_shifted = mem_rdata_in >> {offs_q, 3'b000};
    unique case (func3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // Writeback and status pulses; writeback address/data hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      reg_we_q   <= 1'b0;
      misalign_q <= idle_req && misaligned;
      bus_err_q  <= tmo_hit;
      if (in_bus && mem_ack_in && is_load_q && (rd_q != 5'd0)) begin
        reg_we_q   <= 1'b1;
        reg_addr_q <= rd_q;
        reg_data_q <= load_data;
      end
    end
  end

  assign mem_req_out        = in_bus;
  assign mem_we_out         = in_bus && we_q;
  assign mem_addr_out       = addr_q;
  assign mem_wdata_out      = wdata_q;
  assign mem_wstrb_out      = wstrb_q;
  assign reg_we_out         = reg_we_q;
  assign reg_write_addr_out = reg_addr_q;
  assign reg_write_data_out = reg_data_q;
  assign hold_flag_out      = accept || in_bus;
  assign misalign_out       = misalign_q;
  assign bus_err_out        = bus_err_q;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: stimulus pushes expected bus requests,
// writebacks and pulses; a negedge monitor pops and compares them.
module tb_core_lsu;

  localparam int KBus = 0;
  localparam int KWb  = 1;
  localparam int KMis = 2;
  localparam int KErr = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        we;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_func3 = '0;
  logic [31:0] ex_addr = '0, ex_sdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic        reg_we, hold, misalign, bus_err;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   hold_total = 0;
  int   req_starts = 0;
  int   req_run = 0;
  int   last_req_len = 0;
  int   hold_run = 0;
  int   last_hold_len = 0;

  core_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_in(ex_valid), .ex_is_load_in(ex_is_load), .ex_is_store_in(ex_is_store),
    .ex_func3_in(ex_func3), .ex_addr_in(ex_addr), .ex_store_data_in(ex_sdata),
    .ex_rd_in(ex_rd),
    .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_wstrb_out(mem_wstrb),
    .mem_ack_in(mem_ack), .mem_rdata_in(mem_rdata),
    .reg_we_out(reg_we), .reg_write_addr_out(reg_waddr), .reg_write_data_out(reg_wdata),
    .hold_flag_out(hold), .misalign_out(misalign), .bus_err_out(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic we, input bit chk_data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.strb = strb; e.we = we;
    e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request for one cycle; caller is at posedge+1.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_func3 = f3; ex_addr = a; ex_sdata = sd; ex_rd = rd;
    step(1);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic give_ack(input int wait_cycles, input logic [31:0] rdata);
    step(wait_cycles);
    mem_ack = 1'b1; mem_rdata = rdata;
    step(1);
    mem_ack = 1'b0;
  endtask

  task automatic take(input int kind, input string name, output exp_t it, output bit ok);
    n_cmp++;
    ok = 1'b0;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got output with empty scoreboard, required none", name);
    end else begin
      it = sb.pop_front();
      if (it.kind != kind) begin
        n_fail++;
        $display("FAIL order_%s: got event kind %0d required kind %0d", name, kind, it.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard head.
  initial begin
    exp_t it;
    exp_t cur;
    bit   ok;
    bit   in_bus;
    in_bus = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        in_bus = 1'b0;
        req_run = 0;
        hold_run = 0;
      end else begin
        if (hold === 1'b1) begin
          hold_total++;
          hold_run++;
        end else if (hold_run != 0) begin
          last_hold_len = hold_run;
          hold_run = 0;
        end
        if (reg_we === 1'b1) begin
          take(KWb, "wb", it, ok);
          if (ok) begin
            chk("wb_addr", {27'd0, reg_waddr}, it.addr);
            chk("wb_data", reg_wdata, it.data);
          end
        end
        if (misalign === 1'b1) take(KMis, "misalign", it, ok);
        if (bus_err === 1'b1) take(KErr, "bus_err", it, ok);
        if (mem_req === 1'b1) begin
          req_run++;
          if (!in_bus) begin
            in_bus = 1'b1;
            req_starts++;
            take(KBus, "bus", it, ok);
            if (ok) begin
              cur = it;
              chk("bus_addr", mem_addr, it.addr);
              chk("bus_we", {31'd0, mem_we}, {31'd0, it.we});
              chk("bus_strb", {28'd0, mem_wstrb}, {28'd0, it.strb});
              if (it.chk_data) chk("bus_wdata", mem_wdata, it.data);
              chk("bus_hold", {31'd0, hold}, 32'd1);
            end
          end else if (mem_addr !== cur.addr || mem_wstrb !== cur.strb || mem_we !== cur.we ||
                       (cur.chk_data && mem_wdata !== cur.data)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bus_stable: got addr %h strb %b, required addr %h strb %b",
                     mem_addr, mem_wstrb, cur.addr, cur.strb);
          end
        end else begin
          if (req_run != 0) last_req_len = req_run;
          req_run = 0;
          in_bus = 1'b0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int h0;
    int r0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_strb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
    chk("rst_reg_data", reg_wdata, 32'd0);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_pulses", {30'd0, misalign, bus_err}, 32'd0);

    // LW, ack two cycles after the request starts: hold spans 4 cycles.
    push(KBus, 32'h100, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd5, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h100, 0, 5'd5);
    give_ack(2, 32'hDEADBEEF);
    step(2);
    chk("lw_hold_len", last_hold_len, 32'd4);

    // LB then LBU at 0x103, immediate ack, back to back.
    push(KBus, 32'h100, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd6, 32'hFFFFFF80, 0, 1'b0, 1'b0);
    push(KBus, 32'h100, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd7, 32'h00000080, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b000, 32'h103, 0, 5'd6);
    give_ack(0, 32'h80FF1234);
    do_req(1'b1, 1'b0, 3'b100, 32'h103, 0, 5'd7);
    give_ack(0, 32'h80FF1234);
    step(2);

    // LH upper half (sign), LHU lower half (zero).
    push(KBus, 32'h100, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd8, 32'hFFFF80FF, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b001, 32'h102, 0, 5'd8);
    give_ack(1, 32'h80FF1234);
    push(KBus, 32'h100, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd9, 32'h00001234, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b101, 32'h100, 0, 5'd9);
    give_ack(0, 32'h80FF1234);
    step(2);

    // Stores: SH, SB, SW.
    push(KBus, 32'h200, 32'hABCDABCD, 4'b1100, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd3);
    give_ack(1, 32'h0);
    push(KBus, 32'h200, 32'h78787878, 4'b0010, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 5'd0);
    give_ack(0, 32'h0);
    push(KBus, 32'h300, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b1);
    do_req(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5'd0);
    give_ack(0, 32'h0);
    step(2);

    // Misaligned and illegal requests: no bus cycle, no hold.
    h0 = hold_total;
    r0 = req_starts;
    push(KMis, 0, 0, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h101, 0, 5'd4);
    step(2);
    push(KMis, 0, 0, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b001, 32'h103, 0, 5'd4);
    step(2);
    do_req(1'b1, 1'b0, 3'b011, 32'h100, 0, 5'd4);
    step(2);
    do_req(1'b0, 1'b1, 3'b100, 32'h100, 32'h1, 5'd0);
    step(2);
    chk("nop_hold", hold_total, h0);
    chk("nop_req", req_starts, r0);

    // Timeout: 4 request cycles then bus_err; next LW completes.
    push(KBus, 32'h400, 0, 4'b0000, 1'b0, 1'b0);
    push(KErr, 0, 0, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h400, 0, 5'd10);
    step(6);
    chk("tmo_req_len", last_req_len, 32'd4);
    chk("tmo_hold", {31'd0, hold}, 32'd0);
    push(KBus, 32'h404, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd10, 32'h13572468, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h404, 0, 5'd10);
    give_ack(1, 32'h13572468);
    step(2);

    // Ack on the terminal-count cycle wins over timeout.
    push(KBus, 32'h500, 0, 4'b0000, 1'b0, 1'b0);
    push(KWb, 32'd11, 32'h0BADF00D, 0, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h500, 0, 5'd11);
    give_ack(3, 32'h0BADF00D);
    step(2);

    // Load to x0: bus cycle only; writeback registers keep last value.
    push(KBus, 32'h700, 0, 4'b0000, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h700, 0, 5'd0);
    give_ack(0, 32'hFFFFFFFF);
    step(2);
    chk("x0_keep_addr", {27'd0, reg_waddr}, 32'd11);
    chk("x0_keep_data", reg_wdata, 32'h0BADF00D);

    // Reset two cycles into a pending load, then a stray ack.
    push(KBus, 32'h600, 0, 4'b0000, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h600, 0, 5'd12);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    give_ack(0, 32'h55555555);
    step(2);
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_hold", {31'd0, hold}, 32'd0);
    chk("rst_mid_reg_we", {31'd0, reg_we}, 32'd0);
    chk("rst_mid_reg_addr", {27'd0, reg_waddr}, 32'd0);
    chk("rst_mid_pulses", {30'd0, misalign, bus_err}, 32'd0);

    step(3);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
